// File: rtl/mod_time_counter.sv
// Modulo-MODULUS up/down time counter with registered carry/borrow tick for chaining.
// Optional BCD output (tens/units) is enabled by defining MOD_TIME_COUNTER_BCD_EN.
module mod_time_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 7,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick_out,
    output logic             at_limit,
    output logic             load_err
`ifdef MOD_TIME_COUNTER_BCD_EN
    ,
    output logic [7:0]       bcd
`endif
);

    localparam longint unsigned MAX_STATES = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
    // One extra bit so the range check stays exact when MODULUS == 2^WIDTH.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);

    if (MODULUS < 2 || longint'(MODULUS) > longint'(MAX_STATES)) begin : g_bad_modulus
        $error("mod_time_counter: MODULUS must be in 2..2^WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("mod_time_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] r_count_reg;
    logic [WIDTH-1:0] w_count_next;
    logic             r_tick_reg;
    logic             w_tick_next;
    logic             r_err_reg;
    logic             w_err_next;
    logic             w_load_oob;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_load_oob = ({1'b0, load_val} >= MOD_EXT);
    assign w_at_max   = (r_count_reg == MAX_VAL);
    assign w_at_zero  = (r_count_reg == '0);

    // Priority: clear > load > tick > hold; a tick coinciding with load is dropped.
    always_comb begin
        w_count_next = r_count_reg;
        w_tick_next  = 1'b0;
        w_err_next   = 1'b0;
        if (clear) begin
            w_count_next = '0;
        end else if (load) begin
            if (w_load_oob) begin
                w_count_next = MAX_VAL;
                w_err_next   = 1'b1;
            end else begin
                w_count_next = load_val;
            end
        end else if (tick_in) begin
            if (up_dn) begin
                if (w_at_max) begin
                    w_count_next = '0;
                    w_tick_next  = 1'b1;
                end else begin
                    w_count_next = r_count_reg + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_count_next = MAX_VAL;
                    w_tick_next  = 1'b1;
                end else begin
                    w_count_next = r_count_reg - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_reg <= RST_COUNT;
            r_tick_reg  <= 1'b0;
            r_err_reg   <= 1'b0;
        end else begin
            r_count_reg <= w_count_next;
            r_tick_reg  <= w_tick_next;
            r_err_reg   <= w_err_next;
        end
    end

    assign count    = r_count_reg;
    assign tick_out = r_tick_reg;
    assign load_err = r_err_reg;
    assign at_limit = up_dn ? w_at_max : w_at_zero;

`ifdef MOD_TIME_COUNTER_BCD_EN
    if (MODULUS > 100) begin : g_bad_bcd_modulus
        $error("mod_time_counter: BCD output requires MODULUS <= 100");
    end

    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        int unsigned t;
        t = 32'(v);
        return {4'(t / 10), 4'(t % 10)};
    endfunction

    localparam logic [7:0] RST_BCD = {4'(RESET_VAL / 10), 4'(RESET_VAL % 10)};

    logic [7:0] r_bcd_reg;

    // Encoded from the next count so bcd and count change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd_reg <= RST_BCD;
        end else begin
            r_bcd_reg <= to_bcd(w_count_next);
        end
    end

    assign bcd = r_bcd_reg;
`endif

endmodule

// File: tb/tb_mod_time_counter.sv
// Directed self-checking bench for mod_time_counter: wrap, priority, load error,
// continuous run, async reset and a seconds->minutes chain.
module tb_mod_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = '0;
    logic [6:0] count;
    logic       tick_out;
    logic       at_limit;
    logic       load_err;

    logic       min_clear = 1'b0;
    logic [6:0] min_count;
    logic       min_tick_out;
    logic       min_at_limit;
    logic       min_load_err;
`ifdef MOD_TIME_COUNTER_BCD_EN
    logic [7:0] bcd;
    logic [7:0] min_bcd;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_time_counter #(.MODULUS(60), .WIDTH(7), .RESET_VAL(0)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .up_dn    (up_dn),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick_out (tick_out),
        .at_limit (at_limit),
        .load_err (load_err)
`ifdef MOD_TIME_COUNTER_BCD_EN
        ,
        .bcd      (bcd)
`endif
    );

    mod_time_counter #(.MODULUS(60), .WIDTH(7), .RESET_VAL(0)) u_min (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_out),
        .up_dn    (1'b1),
        .clear    (min_clear),
        .load     (1'b0),
        .load_val (7'd0),
        .count    (min_count),
        .tick_out (min_tick_out),
        .at_limit (min_at_limit),
        .load_err (min_load_err)
`ifdef MOD_TIME_COUNTER_BCD_EN
        ,
        .bcd      (min_bcd)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int c, input int t, input int e);
        $display("[TB] %s: count=%0d tick_out=%0b load_err=%0b", tag, count, tick_out, load_err);
        check({tag, ".count"}, 32'(count), c);
        check({tag, ".tick_out"}, 32'(tick_out), t);
        check({tag, ".load_err"}, 32'(load_err), e);
    endtask

    initial begin
        int pulses;
        int min_pulses;
        bit seen42;

        // Reset held for two edges, then idle.
        cyc();
        cyc();
        expect_state("reset", 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            expect_state("idle", 0, 0, 0);
        end

        // Up wrap from 57.
        load = 1'b1; load_val = 7'd57;
        cyc();
        expect_state("load57", 57, 0, 0);
        load = 1'b0; tick_in = 1'b1; up_dn = 1'b1;
        cyc(); expect_state("up58", 58, 0, 0);
        cyc(); expect_state("up59", 59, 0, 0);
        check("at_limit_up59", 32'(at_limit), 1);
`ifdef MOD_TIME_COUNTER_BCD_EN
        check("bcd59", 32'(bcd), 32'h59);
`endif
        cyc(); expect_state("up_wrap0", 0, 1, 0);
        cyc(); expect_state("up1", 1, 0, 0);
        tick_in = 1'b0;

        // Down wrap from 1.
        load = 1'b1; load_val = 7'd1;
        cyc(); expect_state("load1", 1, 0, 0);
        load = 1'b0; tick_in = 1'b1; up_dn = 1'b0;
        cyc(); expect_state("dn0", 0, 0, 0);
        check("at_limit_dn0", 32'(at_limit), 1);
        cyc(); expect_state("dn_wrap59", 59, 1, 0);
        check("at_limit_dn59", 32'(at_limit), 0);
        cyc(); expect_state("dn58", 58, 0, 0);
        tick_in = 1'b0; up_dn = 1'b1;

        // Priority and load error.
        clear = 1'b1; load = 1'b1; load_val = 7'd30; tick_in = 1'b1;
        cyc(); expect_state("clr_prio", 0, 0, 0);
        clear = 1'b0; load = 1'b1; load_val = 7'd75; tick_in = 1'b0;
        cyc(); expect_state("load_oob", 59, 0, 1);
        load = 1'b1; load_val = 7'd10; tick_in = 1'b1;
        cyc(); expect_state("load_drop_tick", 10, 0, 0);
        load = 1'b0; tick_in = 1'b0;
        cyc(); expect_state("hold10", 10, 0, 0);

        // Continuous run of 125 ticks from 0.
        clear = 1'b1;
        cyc(); expect_state("clr", 0, 0, 0);
        clear = 1'b0; tick_in = 1'b1; up_dn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 125; i++) begin
            cyc();
            if (tick_out) pulses++;
        end
        tick_in = 1'b0;
        $display("[TB] run125: pulses=%0d count=%0d", pulses, count);
        check("run125.pulses", 32'(pulses), 2);
        check("run125.count", 32'(count), 5);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        expect_state("async_rst", 0, 0, 0);
        #1 rst = 1'b0;
        cyc(); expect_state("after_rst", 0, 0, 0);
        tick_in = 1'b1;
        cyc(); expect_state("resume", 1, 0, 0);
        tick_in = 1'b0;

        // Seconds -> minutes chain over one hour of seconds ticks.
        clear = 1'b1; min_clear = 1'b1;
        cyc();
        check("chain_clr.min", 32'(min_count), 0);
        clear = 1'b0; min_clear = 1'b0; tick_in = 1'b1;
        min_pulses = 0;
        seen42 = 1'b0;
        for (int i = 0; i < 3602; i++) begin
            if (i == 3600) tick_in = 1'b0;
            cyc();
            if (min_tick_out) min_pulses++;
            if (min_count == 7'd42 && !seen42) begin
                seen42 = 1'b1;
                $display("[TB] chain: minutes reached 42");
`ifdef MOD_TIME_COUNTER_BCD_EN
                check("chain.bcd42", 32'(min_bcd), 32'h42);
`endif
            end
        end
        $display("[TB] chain: min_pulses=%0d min_count=%0d sec_count=%0d", min_pulses, min_count, count);
        check("chain.seen42", 32'(seen42), 1);
        check("chain.min_pulses", 32'(min_pulses), 1);
        check("chain.min_count", 32'(min_count), 0);
        check("chain.sec_count", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_time_counter.md
Name: mod_time_counter

Overview:
- Parametrised modulo-N up/down time counter; next generation of the fixed 0..59 minutes counter.
- Advances on a one-cycle tick strobe. Supports synchronous clear, load and count direction.
- Emits a registered carry/borrow tick so instances chain directly: seconds -> minutes -> hours.
- Sits in the clock/timekeeping datapath, driven by a prescaler tick or by the upstream counter's tick_out.

Parameters:
- MODULUS, 60, number of states; count range is 0..MODULUS-1; legal range is 2..2^WIDTH.
- WIDTH, 7, width of count and load_val; elaboration fails if 2^WIDTH < MODULUS.
- RESET_VAL, 0, value of count after reset; must be < MODULUS.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- tick_in  input  1  advance strobe; one step per clk edge while high
- up_dn  input  1  1 = count up, 0 = count down; sampled with tick_in
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count, registered
- tick_out  output  1  one-cycle carry (up wrap) or borrow (down wrap) pulse, registered
- at_limit  output  1  combinational: count==MODULUS-1 when up_dn=1, count==0 when up_dn=0
- load_err  output  1  one-cycle pulse, registered: last load had load_val >= MODULUS

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: count=RESET_VAL, tick_out=0, load_err=0.
- Update priority per clk edge: clear > load > tick_in > hold.
- clear=1: count<=0; tick_out<=0; load_err<=0.
- load=1 with load_val<MODULUS: count<=load_val; tick_out<=0; load_err<=0.
- load=1 with load_val>=MODULUS: count<=MODULUS-1; load_err<=1 for one cycle.
- Load on a tick cycle: tick is dropped, not deferred. No tick_out.
- tick_in=1, up_dn=1:
  - count<MODULUS-1: count<=count+1; tick_out<=0.
  - count==MODULUS-1: count<=0; tick_out<=1.
- tick_in=1, up_dn=0:
  - count>0: count<=count-1; tick_out<=0.
  - count==0: count<=MODULUS-1; tick_out<=1.
- Idle cycle (no clear/load/tick): count holds; tick_out<=0; load_err<=0.
- Latency: count and tick_out update on the same edge as the accepted tick. tick_out is high exactly in the cycle count first shows the wrapped value.
- Continuous tick_in=1 advances every cycle. tick_out pulses once per MODULUS ticks.
- Direction change takes effect on the next accepted tick. No state retained from the previous direction.
- Arithmetic: compares use WIDTH-bit unsigned values. count never leaves 0..MODULUS-1, including for MODULUS = 2^WIDTH.
- Reset asserted mid-count: outputs go to reset values immediately, independent of clk. Counting resumes on the first edge after rst deasserts.
- Chaining: downstream tick_in = upstream tick_out. Chained carry adds one cycle of latency per stage; this is accepted.

Optional Feature:
- Macro: MOD_TIME_COUNTER_BCD_EN
- Defined:
  - Adds output bcd, width 8: tens digit in [7:4], units digit in [3:0].
  - bcd is registered and always consistent with count in the same cycle.
  - Reset value is the BCD encoding of RESET_VAL.
  - Elaboration error if MODULUS > 100.
- Undefined: bcd port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and hold: rst=1 for 2 cycles, then 10 idle cycles -> count=0, tick_out=0, load_err=0 throughout.
- Up wrap (MODULUS=60): load 57, then 4 single-cycle ticks with up_dn=1 -> count 58, 59, 0, 1; tick_out=1 only in the cycle count=0.
- Down wrap: load 1, then 3 ticks with up_dn=0 -> count 0, 59, 58; tick_out=1 only in the cycle count=59; at_limit=1 while count=0.
- Priority and error: clear+load+tick on the same edge -> count=0. Then load_val=75 -> count=59, load_err=1 for one cycle. Then load 10 with tick_in=1 -> count=10, tick_out=0.
- Continuous run and async reset: tick_in held high for 125 cycles from 0 -> exactly 2 tick_out pulses, final count=5. rst asserted mid-cycle -> count=0 before the next clk edge.
- Chain with MOD_TIME_COUNTER_BCD_EN: seconds instance (60) feeding a minutes instance (60), 3600 seconds ticks -> minutes wraps 59->0 with one tick_out. At minutes count=42, bcd=0x42.
